enigma_rotor_stepper: RTL and testbench

- Sequencing controller for the three-rotor Enigma datapath. Each rotor-offset stage takes a 6-bit shift and a 26-bit one-hot letter.
- Holds the left, middle and right rotor positions and steps them on every accepted keypress, including notch turnover and the middle-rotor double step.
- Drives the shift inputs and the one-hot key into the combinational datapath, waits a fixed settle time, then captures and returns the enciphered letter over a valid/ready handshake.

---
 rtl/enigma_rotor_stepper.sv | 125 ++++++++++++
 tb/tb_enigma_rotor_stepper.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor_stepper.sv
// Three-rotor Enigma sequencing controller: rotor stepping with notch
// turnover and middle-rotor double step, one-hot key drive, fixed settle
// wait, and valid/ready capture of the enciphered letter.
module enigma_rotor_stepper #(
  parameter int unsigned NOTCH_R = 21,
  parameter int unsigned NOTCH_M = 4,
  parameter int unsigned SETTLE  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_load,
  input  logic [4:0]  cfg_pos_l,
  input  logic [4:0]  cfg_pos_m,
  input  logic [4:0]  cfg_pos_r,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        key_ready,
  output logic [5:0]  shift_l,
  output logic [5:0]  shift_m,
  output logic [5:0]  shift_r,
  output logic [25:0] key_onehot,
  input  logic [25:0] dp_onehot,
  output logic        out_valid,
  output logic [4:0]  out_code,
  output logic        out_err,
  input  logic        out_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_OUT} state_t;

  localparam logic [4:0] NR = 5'(NOTCH_R);
  localparam logic [4:0] NM = 5'(NOTCH_M);
  localparam logic [3:0] SL = 4'(SETTLE);

  state_t     state;
  logic [4:0] pos_l, pos_m, pos_r;
  logic [3:0] cnt;
  logic       key_bad;
  logic [4:0] dp_hits;
  logic [4:0] dp_idx;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] red26(input logic [4:0] v);
    return (v > 5'd25) ? v - 5'd26 : v;
  endfunction

  assign key_ready = (state == ST_IDLE) && !cfg_load;
  assign shift_l   = {1'b0, pos_l};
  assign shift_m   = {1'b0, pos_m};
  assign shift_r   = {1'b0, pos_r};

  // Count set bits of the datapath result and remember the highest one set.
  always_comb begin
    dp_hits = '0;
    dp_idx  = '0;
    for (int unsigned i = 0; i < 26; i++) begin
      if (dp_onehot[i]) begin
        dp_hits = dp_hits + 5'd1;
        dp_idx  = 5'(i);
      end
    end
  end

  // Controller FSM with rotor positions and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pos_l      <= '0;
      pos_m      <= '0;
      pos_r      <= '0;
      cnt        <= '0;
      key_bad    <= 1'b0;
      key_onehot <= '0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            pos_l <= red26(cfg_pos_l);
            pos_m <= red26(cfg_pos_m);
            pos_r <= red26(cfg_pos_r);
          end else if (key_valid) begin
            // Counter starts at SETTLE so the capture edge falls SETTLE+1
            // edges after the accept edge.
            cnt   <= SL;
            state <= ST_SETTLE;
            if (key_code <= 5'd25) begin
              key_onehot <= 26'd1 << key_code;
              key_bad    <= 1'b0;
              pos_r      <= inc26(pos_r);
              if (pos_r == NR || pos_m == NM) pos_m <= inc26(pos_m);
              if (pos_m == NM) pos_l <= inc26(pos_l);
            end else begin
              key_onehot <= '0;
              key_bad    <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            out_valid <= 1'b1;
            out_code  <= (dp_hits == 5'd1) ? dp_idx : 5'd0;
            out_err   <= (dp_hits != 5'd1) || key_bad;
            state     <= ST_OUT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Self-checking bench for enigma_rotor_stepper: directed vectors, an
// arithmetic reference model of the rotor machine, per-cycle comparison.
module tb_enigma_rotor_stepper;

  localparam int NR = 21;
  localparam int NM = 4;
  localparam int ST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_load = 1'b0;
  logic [4:0]  cfg_pos_l = '0, cfg_pos_m = '0, cfg_pos_r = '0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic        key_ready;
  logic [5:0]  shift_l, shift_m, shift_r;
  logic [25:0] key_onehot;
  logic [25:0] dp_onehot = '0;
  logic        out_valid;
  logic [4:0]  out_code;
  logic        out_err;
  logic        out_ready = 1'b0;

  int nchecks = 0;
  int nerr = 0;

  enigma_rotor_stepper #(.NOTCH_R(NR), .NOTCH_M(NM), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .cfg_pos_l(cfg_pos_l), .cfg_pos_m(cfg_pos_m), .cfg_pos_r(cfg_pos_r),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .shift_l(shift_l), .shift_m(shift_m), .shift_r(shift_r),
    .key_onehot(key_onehot), .dp_onehot(dp_onehot),
    .out_valid(out_valid), .out_code(out_code), .out_err(out_err),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: positions as integers, phase 0=idle 1=busy 2=result held.
  int          mp_l, mp_m, mp_r, m_phase, m_wait, m_code;
  logic [25:0] m_oh;
  bit          m_err, m_valid, m_bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_l = 0; mp_m = 0; mp_r = 0; m_phase = 0; m_wait = 0;
      m_oh = '0; m_code = 0; m_err = 0; m_valid = 0; m_bad = 0;
    end else begin
      if (m_phase == 0) begin
        if (cfg_load) begin
          mp_l = (cfg_pos_l > 25) ? int'(cfg_pos_l) - 26 : int'(cfg_pos_l);
          mp_m = (cfg_pos_m > 25) ? int'(cfg_pos_m) - 26 : int'(cfg_pos_m);
          mp_r = (cfg_pos_r > 25) ? int'(cfg_pos_r) - 26 : int'(cfg_pos_r);
        end else if (key_valid) begin
          if (key_code < 26) begin
            int nl, nm;
            nl = (mp_m == NM) ? (mp_l + 1) % 26 : mp_l;
            nm = (mp_r == NR || mp_m == NM) ? (mp_m + 1) % 26 : mp_m;
            mp_r = (mp_r + 1) % 26;
            mp_m = nm;
            mp_l = nl;
            m_oh = '0;
            m_oh[key_code] = 1'b1;
            m_bad = 0;
          end else begin
            m_oh = '0;
            m_bad = 1;
          end
          m_wait = ST + 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_wait--;
        if (m_wait == 0) begin
          if ($countones(dp_onehot) == 1) begin
            for (int i = 0; i < 26; i++) if (dp_onehot[i]) m_code = i;
            m_err = m_bad;
          end else begin
            m_code = 0;
            m_err = 1;
          end
          m_valid = 1;
          m_phase = 2;
        end
      end else if (out_ready) begin
        m_valid = 0;
        m_phase = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("key_ready", key_ready, (m_phase == 0) && !cfg_load);
      check("shift_l", shift_l, mp_l);
      check("shift_m", shift_m, mp_m);
      check("shift_r", shift_r, mp_r);
      check("key_onehot", key_onehot, m_oh);
      check("out_valid", out_valid, m_valid);
      check("out_code", out_code, m_code);
      check("out_err", out_err, m_err);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    cfg_load = 1'b1; cfg_pos_l = l; cfg_pos_m = m; cfg_pos_r = r;
    tick;
    cfg_load = 1'b0;
  endtask

  // Offer a key, wait (bounded) for the result, optionally complete the handshake.
  task automatic press(input logic [4:0] code, input logic [25:0] dp, input bit hold);
    int n;
    key_valid = 1'b1; key_code = code; dp_onehot = dp;
    tick;
    key_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    check("latency", n, ST + 1);
    if (!hold) begin
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
  endtask

  task automatic pos(input string name, input int l, input int m, input int r);
    check({name, "_l"}, shift_l, l);
    check({name, "_m"}, shift_m, m);
    check({name, "_r"}, shift_r, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 0);
    check("rst_err", out_err, 0);
    check("rst_onehot", key_onehot, 0);
    pos("rst", 0, 0, 0);
    tick; tick;
    rst_n = 1'b1;
    check("rst_ready", key_ready, 1);

    // Basic encipher
    cfg(0, 0, 0);
    press(5'd0, 26'h0000004, 0);
    pos("basic", 0, 0, 1);
    check("basic_code", out_code, 2);
    check("basic_err", out_err, 0);
    check("basic_onehot", key_onehot, 26'h1);

    // Right notch turnover
    cfg(0, 0, 21);
    press(5'd7, 26'h0000100, 0);
    pos("notch1", 0, 1, 22);
    press(5'd25, 26'h2000000, 0);
    pos("notch2", 0, 1, 23);
    check("z_code", out_code, 25);

    // Double step
    cfg(0, 3, 21);
    press(5'd1, 26'h0000001, 0);
    pos("dbl1", 0, 4, 22);
    press(5'd2, 26'h0000010, 0);
    pos("dbl2", 1, 5, 23);
    press(5'd3, 26'h0000020, 0);
    pos("dbl3", 1, 5, 24);

    // Wrap on all rotors
    cfg(25, 4, 25);
    press(5'd4, 26'h0000040, 0);
    pos("wrap", 0, 5, 0);

    // Out-of-range start positions
    cfg(31, 30, 26);
    pos("reduce", 5, 4, 0);

    // Back-pressure with ignored cfg_load
    cfg(2, 9, 11);
    press(5'd10, 26'h0001000, 1);
    cfg_load = 1'b1; cfg_pos_l = 5'd7; cfg_pos_m = 5'd7; cfg_pos_r = 5'd7;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_valid", out_valid, 1);
      check("bp_code", out_code, 12);
      check("bp_ready", key_ready, 0);
    end
    cfg_load = 1'b0;
    pos("bp_pos", 2, 9, 12);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp_drop", out_valid, 0);
    check("bp_ready_back", key_ready, 1);
    check("bp_code_hold", out_code, 12);

    // Non-one-hot datapath result
    press(5'd5, 26'h0000006, 0);
    check("multi_err", out_err, 1);
    check("multi_code", out_code, 0);
    pos("multi_pos", 2, 9, 13);

    // Invalid key: no stepping, flagged
    press(5'd27, 26'h0000004, 0);
    pos("badkey_pos", 2, 9, 13);
    check("badkey_err", out_err, 1);
    check("badkey_onehot", key_onehot, 0);

    // Reset during SETTLE
    cfg(3, 3, 3);
    key_valid = 1'b1; key_code = 5'd9; dp_onehot = 26'h0000200;
    tick;
    key_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    pos("arst", 0, 0, 0);
    check("arst_onehot", key_onehot, 0);
    check("arst_valid", out_valid, 0);
    check("arst_code", out_code, 0);
    check("arst_err", out_err, 0);
    tick;
    rst_n = 1'b1;
    check("arst_ready", key_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("arst_quiet", out_valid, 0);
    end

    // Clean operation after reset
    press(5'd24, 26'h0800000, 0);
    pos("post", 0, 0, 1);
    check("post_code", out_code, 23);
    tick; tick;

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
